trng_reader: RTL and testbench
==============================

# trng_reader

Host-side sequencer for the dual-base TRNG sampler. It drives the sampler's calibrate/read handshake (`iCalib`, `iRead`, `iSel_base`) and watches its `oReady`/`oRandom` outputs. Each completed 32-bit word is pushed into a small show-ahead FIFO that the peripheral register block pops. All logic runs in the system clock domain. The sampler's internal clock-divider and synchronizer latency is absorbed by level-based handshakes and per-phase timeouts.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: word FIFO depth; power of two, ≥2.
- `TIMEOUT_W`, default 16: width of the per-phase timeout counter.

Ports:
- `iClk`  in  1: system clock, single clock domain.
- `iRst`  in  1: synchronous, active-high reset.
- `iEn`  in  1: block enable; low forces IDLE and flushes the FIFO.
- `iStart`  in  1: pulse; latches `iSel_base` and starts calibration.
- `iSel_base`  in  1: base select (0 = long, 1 = short), sampled only on `iStart`.
- `iTimeout`  in  `TIMEOUT_W`: cycles allowed per handshake phase; 0 disables the timeout.
- `oCalib`  out  1: to sampler `iCalib`.
- `oRead`  out  1: to sampler `iRead`.
- `oSel_base`  out  1: to sampler `iSel_base`; the latched selection.
- `iTrng_ready`  in  1: from sampler `oReady`.
- `iTrng_random`  in  32: from sampler `oRandom`.
- `oValid`  out  1: FIFO non-empty.
- `oData`  out  32: FIFO head word; reads 0 when empty.
- `iPop`  in  1: consume the head word; ignored when `oValid` = 0.
- `oCount`  out  `$clog2(FIFO_DEPTH+1)`: FIFO occupancy.
- `oBusy`  out  1: FSM not in IDLE or ERROR.
- `oError`  out  1: sticky timeout flag.
- `oHealth_fail`  out  1: sticky repetition-test failure (see Configuration).

## Operation
- Reset, or `iEn` = 0: every output is 0. The FSM goes to IDLE, the FIFO is emptied, and all sticky flags are cleared.
- FSM states and transitions:
  - **IDLE**: on `iStart`, latch `iSel_base` into `oSel_base` and go to CALIB.
  - **CALIB**: hold `oCalib` = 1 until `iTrng_ready` = 1, then go to FILL. `oCalib` drops the cycle after ready is seen.
  - **FILL**: if `oCount` < `FIFO_DEPTH`, go to REQ. Otherwise stay; the sampler stays READY with its rings disabled.
  - **REQ**: hold `oRead` = 1 until `iTrng_ready` = 0, i.e. the sampler has entered COLLECT. Then drop `oRead` and go to WAIT.
  - **WAIT**: when `iTrng_ready` = 1, capture `iTrng_random`, push it to the FIFO, and go to FILL.
  - **ERROR**: entered from CALIB, REQ or WAIT on timeout. `oError` = 1 and `oCalib`/`oRead` are 0. Leaves to CALIB on `iStart`, which also clears `oError`.
- Timeout counter:
  - Cleared on every state entry and incremented each cycle in CALIB, REQ and WAIT.
  - Reaching `iTimeout` (nonzero) → ERROR. Saturates; never wraps.
- `iStart` is ignored outside IDLE and ERROR. A re-calibration (new base) requires `iRst` or an `iEn` low pulse, because the sampler only accepts calibration from its own IDLE state.
- FIFO behaviour:
  - Space is checked before REQ, so a push never overflows.
  - Simultaneous push and pop: `oCount` unchanged, and the head advances correctly, including the empty→push/pop-of-nothing case (`iPop` ignored while empty).
- Pointers wrap modulo `FIFO_DEPTH`.

## Timing
- `oCalib`, `oRead`, `oBusy` and `oError` are registered.
- `oData` is combinational from the FIFO RAM at the registered head pointer.
- A pushed word is visible on `oData`/`oValid` the cycle after the WAIT capture edge.
- The pop takes effect at the clock edge; the next word appears the following cycle.
- Minimum `oRead` low time between requests equals one full sampler collect (32 divided clocks). This guarantees a fresh rising edge in the sampler domain.
- End-to-end latency per word is not fixed. It is bounded by 3×`iTimeout` when the timeout is enabled.

## Configuration
- `TRNG_READER_HEALTH_EN` defined:
  - Each captured word is compared with the previous captured word, held in a 32-bit register cleared on reset.
  - An equal word is discarded (not pushed), `oHealth_fail` is set (sticky until reset or `iEn` low), and the FSM returns to FILL.
- Undefined: no compare register, `oHealth_fail` is tied to 0, and every word is pushed.

## Structure
- `trng_reader_pkg` holds:
  - the FSM state enum (IDLE, CALIB, FILL, REQ, WAIT, ERROR);
  - the `WORD_W` = 32 constant.
- The sub-module `trng_word_fifo` (show-ahead FIFO, parameter `DEPTH`, synchronous reset) holds the storage and pointers. The FSM and timeout logic stay in the top module.

## Test plan
The bench models the sampler with settable ready delays.

1. **Calibrate and fill.** Reset, `iStart` with `iSel_base` = 1, model calib 5 cycles → `oSel_base` = 1, `oCalib` high exactly until ready. FIFO fills to 4 words 0x11111111..0x44444444 in order, then no `oRead` while full.
2. **Pop with concurrent push.** Pop while full with a word pending in WAIT → `oCount` goes 4→3→4. `oData` order is preserved.
3. **Timeout.** `iTimeout` = 20, model never drops ready after `oRead` → `oError` = 1 at cycle 20 of REQ, `oRead` = 0, `oBusy` = 0. A further `iStart` returns to CALIB and clears `oError`.
4. **Disable mid-operation.** `iEn` low during WAIT → all outputs 0 next cycle and FIFO empty. A late ready pulse from the model is ignored.
5. **Health test.** With `TRNG_READER_HEALTH_EN` defined, model returns 0xDEADBEEF twice → second word dropped, `oCount` = 1, `oHealth_fail` = 1. Undefined: `oCount` = 2, flag stays 0.
6. **Timeout disabled.** `iTimeout` = 0 with a 70000-cycle ready delay → no error, word delivered.

Source files
------------

// File: rtl/trng_reader_pkg.sv
// trng_reader_pkg: shared word width and FSM state encoding for the TRNG reader
package trng_reader_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CALIB,
    S_FILL,
    S_REQ,
    S_WAIT,
    S_ERROR
  } state_t;
endpackage

// File: rtl/trng_word_fifo.sv
// trng_word_fifo: show-ahead word FIFO; head word is combinational, empty reads 0
module trng_word_fifo
  import trng_reader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         iClk,
  input  logic                         iRst,
  input  logic                         iPush,
  input  logic [WORD_W-1:0]            iData,
  input  logic                         iPop,
  output logic                         oValid,
  output logic [WORD_W-1:0]            oData,
  output logic [$clog2(DEPTH+1)-1:0]   oCount
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic do_pop, do_push;
  assign do_pop  = iPop && count != '0;
  assign do_push = iPush && (count != CW'(DEPTH) || do_pop);
  assign oValid  = count != '0;
  assign oData   = oValid ? mem[rd_ptr] : '0;
  assign oCount  = count;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge iClk) begin
    if (iRst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  // storage needs no reset; occupancy alone decides what is visible
  always_ff @(posedge iClk) begin
    if (do_push) mem[wr_ptr] <= iData;
  end
endmodule

// File: rtl/trng_reader.sv
// trng_reader: sequences sampler calibrate/read handshakes into a word FIFO; optional TRNG_READER_HEALTH_EN repetition test
module trng_reader
  import trng_reader_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                              iClk,
  input  logic                              iRst,
  input  logic                              iEn,
  input  logic                              iStart,
  input  logic                              iSel_base,
  input  logic [TIMEOUT_W-1:0]              iTimeout,
  output logic                              oCalib,
  output logic                              oRead,
  output logic                              oSel_base,
  input  logic                              iTrng_ready,
  input  logic [WORD_W-1:0]                 iTrng_random,
  output logic                              oValid,
  output logic [WORD_W-1:0]                 oData,
  input  logic                              iPop,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   oCount,
  output logic                              oBusy,
  output logic                              oError,
  output logic                              oHealth_fail
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  state_t state, state_nxt;
  logic [TIMEOUT_W-1:0] tmo_cnt, tmo_inc;
  logic clr, timed, tmo_hit, capture, dup, push;
  assign clr     = iRst || !iEn;
  assign timed   = state inside {S_CALIB, S_REQ, S_WAIT};
  assign tmo_inc = &tmo_cnt ? tmo_cnt : tmo_cnt + TIMEOUT_W'(1);
  assign tmo_hit = iTimeout != '0 && tmo_inc >= iTimeout;
  assign capture = state == S_WAIT && iTrng_ready;
  assign push    = capture && !dup;
`ifdef TRNG_READER_HEALTH_EN
  logic [WORD_W-1:0] prev_word;
  logic health_fail;
  assign dup          = prev_word == iTrng_random;
  assign oHealth_fail = health_fail;
  // remember the last captured word and flag any exact repeat
  always_ff @(posedge iClk) begin
    if (clr) begin
      prev_word   <= '0;
      health_fail <= 1'b0;
    end else if (capture) begin
      prev_word <= iTrng_random;
      if (dup) health_fail <= 1'b1;
    end
  end
`else
  assign dup          = 1'b0;
  assign oHealth_fail = 1'b0;
`endif
  // handshake sequencing; progress wins over a timeout in the same cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = iStart ? S_CALIB : S_IDLE;
      S_CALIB: state_nxt = iTrng_ready ? S_FILL : tmo_hit ? S_ERROR : S_CALIB;
      S_FILL:  state_nxt = oCount < CW'(FIFO_DEPTH) ? S_REQ : S_FILL;
      S_REQ:   state_nxt = !iTrng_ready ? S_WAIT : tmo_hit ? S_ERROR : S_REQ;
      S_WAIT:  state_nxt = iTrng_ready ? S_FILL : tmo_hit ? S_ERROR : S_WAIT;
      S_ERROR: state_nxt = iStart ? S_CALIB : S_ERROR;
      default: state_nxt = S_IDLE;
    endcase
  end
  // state, phase timer and registered handshake/status outputs
  always_ff @(posedge iClk) begin
    if (clr) begin
      state     <= S_IDLE;
      tmo_cnt   <= '0;
      oCalib    <= 1'b0;
      oRead     <= 1'b0;
      oBusy     <= 1'b0;
      oError    <= 1'b0;
      oSel_base <= 1'b0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= state_nxt != state ? '0 : timed ? tmo_inc : tmo_cnt;
      oCalib  <= state_nxt == S_CALIB;
      oRead   <= state_nxt == S_REQ;
      oBusy   <= !(state_nxt inside {S_IDLE, S_ERROR});
      oError  <= state_nxt == S_ERROR;
      if (state == S_IDLE && iStart) oSel_base <= iSel_base;
    end
  end
  trng_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .iClk   (iClk),
    .iRst   (clr),
    .iPush  (push),
    .iData  (iTrng_random),
    .iPop   (iPop),
    .oValid (oValid),
    .oData  (oData),
    .oCount (oCount)
  );
endmodule

// File: tb/tb_trng_reader.sv
// tb_trng_reader: directed + random checks of trng_reader against a sampler model and word scoreboard
module tb_trng_reader;
  import trng_reader_pkg::*;
  localparam int DEPTH = 4;
  localparam int TW = 16;
  localparam int CW = $clog2(DEPTH+1);
`ifdef TRNG_READER_HEALTH_EN
  localparam bit HEALTH = 1'b1;
`else
  localparam bit HEALTH = 1'b0;
`endif
  logic iClk = 1'b0;
  logic iRst = 1'b1, iEn = 1'b0, iStart = 1'b0, iSel_base = 1'b0, iPop = 1'b0;
  logic [TW-1:0] iTimeout = '0;
  logic iTrng_ready = 1'b0;
  logic [31:0] iTrng_random = '0;
  logic oCalib, oRead, oSel_base, oValid, oBusy, oError, oHealth_fail;
  logic [31:0] oData;
  logic [CW-1:0] oCount;
  int tests = 0, fails = 0;
  int m_mode = 0, m_cnt = 0, calib_dly = 5, drop_dly = 1, collect_dly = 8, words_left = -1;
  bit m_rst = 1'b1, never_drop = 1'b0, rand_dly = 1'b0;
  logic [31:0] w, last_word = '0;
  logic [31:0] word_q[$];
  logic [31:0] exp_q[$];

  trng_reader #(.FIFO_DEPTH(DEPTH), .TIMEOUT_W(TW)) dut (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iStart(iStart), .iSel_base(iSel_base),
    .iTimeout(iTimeout), .oCalib(oCalib), .oRead(oRead), .oSel_base(oSel_base),
    .iTrng_ready(iTrng_ready), .iTrng_random(iTrng_random), .oValid(oValid),
    .oData(oData), .iPop(iPop), .oCount(oCount), .oBusy(oBusy), .oError(oError),
    .oHealth_fail(oHealth_fail)
  );

  always #5 iClk = ~iClk;

  // sampler model: idle -> ready after calib delay, drops ready on read, presents a word after collect delay
  always @(negedge iClk) begin
    if (m_rst) begin
      m_mode = 0; m_cnt = 0; iTrng_ready = 1'b0; iTrng_random = '0;
    end else if (m_mode == 0) begin
      if (oCalib) begin
        m_cnt++;
        if (m_cnt >= calib_dly) begin m_mode = 1; m_cnt = 0; iTrng_ready = 1'b1; end
      end
    end else if (m_mode == 1) begin
      if (oRead && !never_drop) begin
        m_cnt++;
        if (m_cnt >= drop_dly) begin m_mode = 2; m_cnt = 0; iTrng_ready = 1'b0; end
      end
    end else if (words_left != 0) begin
      m_cnt++;
      if (m_cnt >= collect_dly) begin
        w = word_q.size() != 0 ? word_q.pop_front() : $urandom;
        iTrng_random = w; iTrng_ready = 1'b1; m_mode = 1; m_cnt = 0;
        if (words_left > 0) words_left--;
        if (!(HEALTH && w == last_word)) exp_q.push_back(w);
        last_word = w;
        if (rand_dly) collect_dly = $urandom_range(3, 30);
      end
    end
  end

  task automatic tick();
    @(posedge iClk); #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hard_reset();
    iRst = 1'b1; m_rst = 1'b1; iEn = 1'b1; iStart = 1'b0; iPop = 1'b0;
    calib_dly = 5; drop_dly = 1; collect_dly = 8; never_drop = 1'b0;
    words_left = -1; rand_dly = 1'b0; last_word = '0;
    exp_q.delete(); word_q.delete();
    tick(); tick();
    iRst = 1'b0; m_rst = 1'b0;
  endtask

  task automatic start(input logic sel);
    iSel_base = sel; iStart = 1'b1; tick(); iStart = 1'b0;
  endtask

  task automatic wait_count(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && oCount != CW'(n); i++) tick();
    chk(tag, oCount, n);
  endtask

  task automatic pop_chk(input string tag);
    chk(tag, oData, exp_q.size() != 0 ? exp_q[0] : 32'h0);
    iPop = 1'b1; tick(); iPop = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  initial begin
    int c;
    bit p, v;
    // 1: calibrate and fill
    hard_reset();
    iTimeout = 16'd1000;
    chk("reset_outs", {oCalib, oRead, oSel_base, oValid, oBusy, oError, oHealth_fail, oCount, oData}, 0);
    word_q = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    start(1'b1);
    chk("sel_base", oSel_base, 1);
    c = 0;
    while (oCalib && c < 100) begin c++; tick(); end
    chk("calib_len", c, 5);
    chk("calib_drop_ready", iTrng_ready, 1);
    wait_count(4, 400, "fill4");
    chk("head_first", oData, 32'h11111111);
    c = 0;
    repeat (40) begin tick(); c += int'(oRead); end
    chk("no_read_full", c, 0);
    chk("busy_full", oBusy, 1);
    // 2: pop while full, then pop on the same edge a new word is captured
    pop_chk("pop_head0");
    chk("cnt_after_pop", oCount, 3);
    for (int i = 0; i < 100 && !oRead; i++) tick();
    for (int i = 0; i < 100 && oRead; i++) tick();
    c = 0;
    while (!iTrng_ready && c < 200) begin @(negedge iClk); #1; c++; end
    chk("pop_sim_data", oData, exp_q[0]);
    iPop = 1'b1; @(posedge iClk); #1; iPop = 1'b0;
    void'(exp_q.pop_front());
    chk("cnt_push_pop", oCount, 3);
    chk("head_after_push_pop", oData, 32'h33333333);
    wait_count(4, 200, "refill4");
    // random phase: random pops and collect delays against the scoreboard
    rand_dly = 1'b1; drop_dly = 2;
    for (int i = 0; i < 300; i++) begin
      p = $urandom_range(0, 2) == 0;
      v = oValid;
      iPop = p;
      if (p && v) chk("rand_data", oData, exp_q[0]);
      tick();
      iPop = 1'b0;
      if (p && v) void'(exp_q.pop_front());
      chk("rand_cnt", oCount, exp_q.size());
    end
    // 3: timeout in REQ
    hard_reset();
    iTimeout = 16'd20; never_drop = 1'b1; calib_dly = 3;
    start(1'b0);
    chk("sel_base0", oSel_base, 0);
    for (int i = 0; i < 100 && !oRead; i++) tick();
    c = 0;
    while (oRead && c < 100) begin c++; tick(); end
    chk("req_len", c, 20);
    chk("err_set", oError, 1);
    chk("err_busy", {oBusy, oRead, oCalib}, 0);
    repeat (5) tick();
    chk("err_sticky", oError, 1);
    start(1'b0);
    chk("err_cleared", oError, 0);
    chk("recal", {oCalib, oBusy}, 2'b11);
    // 4: disable mid-WAIT
    hard_reset();
    iTimeout = '0;
    start(1'b1);
    wait_count(2, 200, "dis_fill2");
    for (int i = 0; i < 100 && !oRead; i++) tick();
    for (int i = 0; i < 100 && oRead; i++) tick();
    tick();
    iEn = 1'b0; tick();
    chk("dis_outs", {oCalib, oRead, oSel_base, oValid, oBusy, oError, oHealth_fail, oCount, oData}, 0);
    repeat (20) tick();
    chk("dis_late_ready", {oValid, oBusy, oCount}, 0);
    iEn = 1'b1;
    repeat (20) tick();
    chk("reen_idle", {oCalib, oRead, oSel_base, oValid, oBusy, oError, oCount}, 0);
    iPop = 1'b1; tick(); iPop = 1'b0;
    chk("pop_empty", {oValid, oCount, oData}, 0);
    // 5: repetition health test
    hard_reset();
    word_q = {32'hDEADBEEF, 32'hDEADBEEF}; words_left = 2;
    start(1'b0);
    for (int i = 0; i < 300 && words_left != 0; i++) tick();
    repeat (10) tick();
    chk("health_cnt", oCount, HEALTH ? 1 : 2);
    chk("health_cnt_model", oCount, exp_q.size());
    chk("health_flag", oHealth_fail, HEALTH);
    chk("health_data", oData, 32'hDEADBEEF);
    // 6: timeout disabled, very slow word
    hard_reset();
    calib_dly = 3; collect_dly = 70000; words_left = 1; word_q = {32'hCAFEF00D};
    start(1'b0);
    wait_count(1, 71000, "slow_word");
    chk("slow_no_err", oError, 0);
    chk("slow_data", oData, 32'hCAFEF00D);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
